dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's data port: services memen/wea/addr/writedata, returns readdata.
//  Backs a byte-writable data RAM plus a small MMIO window: LED register, free-running cycle counter,
//  and a console TX FIFO drained over a valid/ready handshake. Sits beside the core at SoC top level.
// PARAMETERS
//  DEPTH_WORDS  4096           data RAM size in 32-bit words (power of two)
//  FIFO_DEPTH   8              TX FIFO entries (power of two, >=2)
//  MMIO_BASE    32'hBFAF_0000  base of 16-byte MMIO window (16-byte aligned)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   asynchronous, active-high reset
//  memen      in   1   data access enable from core (M stage)
//  wea        in   4   byte write enables, bit i -> writedata[8i+7:8i]; 0000 = read
//  addr       in   32  byte address (core aluout), word aligned
//  writedata  in   32  store data, already lane-replicated by core
//  readdata   out  32  load data, combinational, same cycle as request
//  led        out  16  LED register
//  tx_data    out  8   FIFO head byte
//  tx_valid   out  1   FIFO non-empty
//  tx_ready   in   1   sink accepts head this cycle
//  addr_err   out  1   one-cycle pulse after unmapped access (see CONFIGURATION)
// BEHAVIOUR
//  Reset: led=0, counter=0, FIFO empty (tx_valid=0, tx_data=0), overflow=0, addr_err=0; readdata=0
//   while reset high. RAM contents not reset.
//  Decode: MMIO if addr[31:4]==MMIO_BASE[31:4]; RAM if addr < DEPTH_WORDS*4; else unmapped.
//  RAM: index addr[log2(DEPTH_WORDS)+1:2]; read async; write at clk edge per set wea bits when memen.
//  readdata = 0 when memen=0, unmapped, or write-only/unused MMIO offset.
//  MMIO map (offset = addr[3:0]):
//   0x0 LED     RW  bits[15:0]; write honours wea[1:0]; read zero-extends.
//   0x4 COUNTER RO  +1 every cycle, wraps FFFF_FFFF->0; writes ignored.
//   0x8 TXDATA  WO  write with wea[0]=1 pushes writedata[7:0]; reads return 0.
//   0xC STATUS  RW  [0]=empty [1]=full [2]=overflow sticky [15:8]=count; write with
//                   writedata[2]=1 & wea[0] clears overflow (same-cycle drop re-sets it: set wins).
//  FIFO: pop when tx_valid&tx_ready. Push accepted if count<FIFO_DEPTH or pop same cycle;
//   otherwise byte dropped, overflow<=1. Simultaneous push+pop: count unchanged, order preserved.
//   Empty push: byte visible on tx_data, tx_valid=1 next cycle (1-cycle latency). Pointers wrap mod depth.
//   tx_data/tx_valid stable while tx_valid&!tx_ready.
//  Mid-operation reset: FIFO contents and pending bytes discarded; counter restarts at 0.
//  One access per cycle; no stalls or back-pressure to the core.
// CONFIGURATION
//  DMEM_ADDR_CHECK_EN defined: memen access to unmapped address -> addr_err=1 for exactly the next
//   cycle; write suppressed, readdata 0. Back-to-back unmapped accesses keep addr_err high.
//  Not defined: addr_err tied 0; unmapped accesses still ignored/read 0.
// TESTING
//  1 RAM bytes: write 0x11223344 wea=1111 @0x10, then wea=0100 data 0x00AA0000 -> read 0x11AA3344.
//  2 Counter: release reset, read 0x4 after 10 cycles -> 10 (+/-0 vs bench cycle count); force near
//    wrap -> observe FFFF_FFFF then 0.
//  3 FIFO full/overflow: tx_ready=0, push 9 bytes 0x01..0x09 -> STATUS full=1, overflow=1, count=8;
//    raise tx_ready -> 0x01..0x08 emitted, one per cycle, then tx_valid=0.
//  4 Push+pop when full: tx_ready=1 same cycle as push 0x55 -> accepted, overflow stays 0, 0x55 last out.
//  5 Overflow clear: write STATUS 0x4 -> overflow=0; LED write 0xBEEF wea=0011 -> led=0xBEEF.
//  6 DMEM_ADDR_CHECK_EN: write 0x12345678 to 0x8000_0000 -> addr_err one cycle, RAM unchanged,
//    readdata 0; without macro addr_err never asserts.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-port responder: byte-writable RAM plus an MMIO window (LED, cycle counter, TX FIFO, status).
// Define DMEM_ADDR_CHECK_EN to flag memen accesses to unmapped addresses on addr_err.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'hBFAF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memen,
  input  logic [3:0]  wea,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        addr_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   led_q;
  logic [31:0]   ctr_q;
  logic          ovf_q, ovf_d;

  logic          is_mmio, is_ram, unmapped;
  logic [1:0]    off;
  logic [AW-1:0] ram_idx;
  logic          led_we, tx_push, st_clr;
  logic          fifo_empty, fifo_full, pop, push_ok;

  assign is_mmio  = (addr[31:4] == MMIO_BASE[31:4]);
  assign is_ram   = (addr[31:AW+2] == '0);
  assign unmapped = !is_mmio && !is_ram;
  assign off      = addr[3:2];
  assign ram_idx  = addr[AW+1:2];

  assign led_we  = memen && is_mmio && (off == 2'd0);
  assign tx_push = memen && is_mmio && (off == 2'd2) && wea[0];
  assign st_clr  = memen && is_mmio && (off == 2'd3) && wea[0] && writedata[2];

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop        = !fifo_empty && tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = tx_push && (!fifo_full || pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A dropped byte beats a same-cycle clear so no overflow event is lost.
  always_comb begin
    ovf_d = ovf_q;
    if (tx_push && !push_ok) ovf_d = 1'b1;
    else if (st_clr)         ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (memen && is_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (wea[b]) ram_q[ram_idx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= writedata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      led_q    <= '0;
      ctr_q    <= '0;
    end else begin
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      ctr_q <= ctr_q + 32'd1;
      if (led_we && wea[0]) led_q[7:0]  <= writedata[7:0];
      if (led_we && wea[1]) led_q[15:8] <= writedata[15:8];
    end
  end

  always_comb begin
    readdata = '0;
    if (!reset && memen) begin
      if (is_ram) begin
        readdata = ram_q[ram_idx];
      end else if (is_mmio) begin
        case (off)
          2'd0:    readdata = {16'h0, led_q};
          2'd1:    readdata = ctr_q;
          2'd3:    readdata = {16'h0, 8'(cnt_q), 5'h0, ovf_q, fifo_full, fifo_empty};
          default: readdata = '0;
        endcase
      end
    end
  end

  assign led      = led_q;
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

`ifdef DMEM_ADDR_CHECK_EN
  logic addr_err_q, addr_err_d;
  logic unused_ok;
  assign addr_err_d = memen && unmapped;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) addr_err_q <= 1'b0;
    else       addr_err_q <= addr_err_d;
  end
  assign addr_err  = addr_err_q;
  assign unused_ok = ^addr[1:0];
`else
  logic unused_ok;
  assign addr_err  = 1'b0;
  assign unused_ok = ^{addr[1:0], unmapped};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, FIFO/counter/reset sequences, randomized traffic vs a queue-based model.
module tb_dmem_responder;
  localparam logic [31:0] MB         = 32'hBFAF_0000;
  localparam logic [31:0] RAM_BYTES  = 32'h0000_4000;
  localparam int          FIFO_DEPTH = 8;
`ifdef DMEM_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic        clk, reset, memen, tx_ready;
  logic [3:0]  wea;
  logic [31:0] addr, writedata, readdata;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid, addr_err;

  dmem_responder #(.DEPTH_WORDS(4096), .FIFO_DEPTH(FIFO_DEPTH), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .memen(memen), .wea(wea), .addr(addr),
    .writedata(writedata), .readdata(readdata), .led(led), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] ram_m [int unsigned];
  logic [7:0]  q_m [$];
  logic [15:0] led_m;
  logic [31:0] ctr_m;
  bit          ovf_m, addr_err_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    led_m = '0; ctr_m = '0; ovf_m = 0; addr_err_m = 0;
  endtask

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >= MB) && (a < MB + 32'd16);
  endfunction

  task automatic check_outputs();
    logic [31:0] er;
    bit known;
    er = '0; known = 1;
    if (!reset && memen) begin
      if (in_mmio(addr)) begin
        case (addr - MB)
          32'd0:   er = {16'h0, led_m};
          32'd4:   er = ctr_m;
          32'd12:  er = {16'h0, 8'(q_m.size()), 5'h0, ovf_m,
                         q_m.size() == FIFO_DEPTH, q_m.size() == 0};
          default: er = '0;
        endcase
      end else if (addr < RAM_BYTES) begin
        if (ram_m.exists(addr >> 2)) er = ram_m[addr >> 2];
        else known = 0;
      end
    end
    if (known) chk("readdata", readdata, er);
    chk("led", {16'h0, led}, {16'h0, led_m});
    chk("tx_valid", {31'h0, tx_valid}, {31'h0, q_m.size() != 0});
    chk("tx_data", {24'h0, tx_data}, {24'h0, (q_m.size() != 0) ? q_m[0] : 8'h00});
    chk("addr_err", {31'h0, addr_err}, {31'h0, addr_err_m});
  endtask

  task automatic model_edge();
    bit push_req, clr, err, drop;
    logic [31:0] w;
    int unsigned idx;
    push_req = 0; clr = 0; err = 0; drop = 0;
    if (memen) begin
      if (in_mmio(addr)) begin
        if (addr - MB == 32'd0) begin
          if (wea[0]) led_m[7:0]  = writedata[7:0];
          if (wea[1]) led_m[15:8] = writedata[15:8];
        end else if (addr - MB == 32'd8) push_req = wea[0];
        else if (addr - MB == 32'd12)    clr = wea[0] && writedata[2];
      end else if (addr < RAM_BYTES) begin
        idx = addr >> 2;
        if (ram_m.exists(idx) || wea == 4'hF) begin
          w = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
          for (int b = 0; b < 4; b++) if (wea[b]) w[8*b +: 8] = writedata[8*b +: 8];
          ram_m[idx] = w;
        end
      end else err = 1;
    end
    if (tx_ready && q_m.size() > 0) void'(q_m.pop_front());
    if (push_req) begin
      if (q_m.size() < FIFO_DEPTH) q_m.push_back(writedata[7:0]);
      else drop = 1;
    end
    if (clr)  ovf_m = 0;
    if (drop) ovf_m = 1;
    ctr_m = ctr_m + 32'd1;
    addr_err_m = ADDR_CHECK && err;
  endtask

  task automatic apply(input logic m, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic r);
    memen = m; wea = w; addr = a; writedata = d; tx_ready = r;
    #1;
    check_outputs();
    if (!reset) model_edge();
  endtask

  task automatic step(input logic m, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic r);
    @(negedge clk);
    apply(m, w, a, d, r);
  endtask

  function automatic logic [31:0] ram_addr(input int unsigned k);
    return (k < 12) ? 32'(k * 4) : 32'h3FF0 + 32'((k - 12) * 4);
  endfunction

  function automatic logic [31:0] unm_addr(input int unsigned k);
    case (k)
      0:       return 32'h0000_4000;
      1:       return 32'h8000_0000;
      2:       return MB + 32'h10;
      3:       return MB - 32'h4;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  typedef struct packed {
    logic        m;
    logic [3:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic        r;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [20];

  initial begin
    tbl[0]  = '{1'b1, 4'h0, MB + 32'd4,   32'h0,         1'b0, 1'b1, 32'd10};
    tbl[1]  = '{1'b1, 4'hF, 32'h10,       32'h1122_3344, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 4'h4, 32'h10,       32'h00AA_0000, 1'b0, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 4'h0, 32'h10,       32'h0,         1'b0, 1'b1, 32'h11AA_3344};
    tbl[4]  = '{1'b1, 4'h3, MB,           32'h0000_BEEF, 1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 4'h0, MB,           32'h0,         1'b0, 1'b1, 32'h0000_BEEF};
    tbl[6]  = '{1'b1, 4'h2, MB,           32'h1234_5678, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 4'h0, MB,           32'h0,         1'b0, 1'b1, 32'h0000_56EF};
    tbl[8]  = '{1'b1, 4'h0, MB + 32'd8,   32'h0,         1'b0, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 4'h0, MB + 32'd12,  32'h0,         1'b0, 1'b1, 32'h1};
    tbl[10] = '{1'b0, 4'h0, 32'h10,       32'h0,         1'b0, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 4'hF, MB + 32'd4,   32'h0,         1'b0, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 4'h0, MB + 32'd4,   32'h0,         1'b0, 1'b1, 32'd22};
    tbl[13] = '{1'b1, 4'hF, 32'h0,        32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
    tbl[14] = '{1'b1, 4'hF, 32'h8000_0000, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
    tbl[15] = '{1'b1, 4'h0, 32'h8000_0000, 32'h0,        1'b0, 1'b1, 32'h0};
    tbl[16] = '{1'b1, 4'h0, 32'h0,        32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
    tbl[17] = '{1'b1, 4'hF, 32'h3FFC,     32'hA5A5_5A5A, 1'b0, 1'b0, 32'h0};
    tbl[18] = '{1'b1, 4'h0, 32'h3FFC,     32'h0,         1'b0, 1'b1, 32'hA5A5_5A5A};
    tbl[19] = '{1'b1, 4'h0, 32'h4000,     32'h0,         1'b0, 1'b1, 32'h0};

    reset = 1'b1; memen = 1'b1; wea = 4'h0; addr = MB + 32'd4; writedata = '0; tx_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_outputs();
    chk("reset readdata", readdata, 32'h0);

    // Release, then nine idle cycles so the first vector reads the counter at cycle 10
    @(negedge clk);
    reset = 1'b0;
    apply(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    repeat (9) step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].m, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].r);
      if (tbl[i].chk) chk($sformatf("vec%0d readdata", i), readdata, tbl[i].exp);
      if (i == 15) chk("addr_err after unmapped", {31'h0, addr_err}, {31'h0, ADDR_CHECK});
    end

    // FIFO fill past capacity with the sink stalled
    for (int k = 1; k <= 9; k++) step(1'b1, 4'h1, MB + 32'd8, 32'(k), 1'b0);
    step(1'b1, 4'h0, MB + 32'd12, 32'h0, 1'b0);
    chk("status full+ovf", readdata, 32'h0000_0806);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      chk($sformatf("drain byte %0d", k), {24'h0, tx_data}, 32'(k));
    end
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    chk("drained tx_valid", {31'h0, tx_valid}, 32'h0);

    // Overflow clear
    step(1'b1, 4'h1, MB + 32'd12, 32'h4, 1'b0);
    step(1'b1, 4'h0, MB + 32'd12, 32'h0, 1'b0);
    chk("status after clear", readdata, 32'h0000_0001);

    // Push while full with a same-cycle pop
    for (int k = 0; k < 8; k++) step(1'b1, 4'h1, MB + 32'd8, 32'h21 + 32'(k), 1'b0);
    step(1'b1, 4'h1, MB + 32'd8, 32'h55, 1'b1);
    step(1'b1, 4'h0, MB + 32'd12, 32'h0, 1'b0);
    chk("status push+pop full", readdata, 32'h0000_0802);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      chk($sformatf("pp byte %0d", k), {24'h0, tx_data}, (k < 7) ? 32'h22 + 32'(k) : 32'h55);
    end

    // Counter wrap
    @(negedge clk);
    force dut.ctr_q = 32'hFFFF_FFFF;
    #1;
    release dut.ctr_q;
    ctr_m = 32'hFFFF_FFFF;
    apply(1'b1, 4'h0, MB + 32'd4, 32'h0, 1'b0);
    chk("counter max", readdata, 32'hFFFF_FFFF);
    step(1'b1, 4'h0, MB + 32'd4, 32'h0, 1'b0);
    chk("counter wrap", readdata, 32'h0);

    // Randomized traffic; prefill the RAM address pool first
    for (int k = 0; k < 16; k++) step(1'b1, 4'hF, ram_addr(k), $urandom, 1'b0);
    for (int n = 0; n < 500; n++) begin
      int unsigned kind, sel;
      logic rdy;
      kind = $urandom_range(9);
      sel  = $urandom_range(15);
      rdy  = 1'($urandom_range(1));
      case (kind)
        0:       step(1'b1, 4'($urandom_range(15)), ram_addr(sel), $urandom, rdy);
        1:       step(1'b1, 4'h0, ram_addr(sel), 32'h0, rdy);
        2:       step(1'b1, 4'h0, MB + 32'((sel % 4) * 4), 32'h0, rdy);
        3, 7, 8: step(1'b1, 4'h1, MB + 32'd8, $urandom, rdy);
        4:       step(1'b1, 4'($urandom_range(3)), MB, $urandom, rdy);
        5:       step(1'b1, 4'h1, MB + 32'd12, 32'h4, rdy);
        6:       step(1'b1, 4'($urandom_range(15)), unm_addr(sel % 5), $urandom, rdy);
        default: step(1'b0, 4'h0, ram_addr(sel), $urandom, rdy);
      endcase
    end

    // Mid-operation reset discards queued bytes and restarts the counter
    for (int k = 0; k < 3; k++) step(1'b1, 4'h1, MB + 32'd8, 32'h70 + 32'(k), 1'b0);
    @(negedge clk);
    reset = 1'b1; memen = 1'b1; wea = 4'h0; addr = MB + 32'd4; tx_ready = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("mid reset tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid reset readdata", readdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    apply(1'b1, 4'h0, MB + 32'd4, 32'h0, 1'b0);
    chk("counter restart", readdata, 32'h0);
    step(1'b1, 4'h0, MB + 32'd12, 32'h0, 1'b0);
    chk("status after reset", readdata, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
